// File: rtl/tm1640_pkg.sv
// rtl/tm1640_pkg.sv - shared constants and types for the TM1640 bus responder.
package tm1640_pkg;

   localparam logic [1:0] CMD_DATA = 2'b01;
   localparam logic [1:0] CMD_DISP = 2'b10;
   localparam logic [1:0] CMD_ADDR = 2'b11;

   localparam int MODE_BIT  = 2;
   localparam int RAM_DEPTH = 16;
   localparam int ADDR_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      SKIP
   } state_e;

   typedef logic [7:0] byte_t;

endpackage

// File: rtl/tm1640_line_sync.sv
// rtl/tm1640_line_sync.sv - synchronizes tm_clk/tm_din and flags start, stop and rising-edge bits.
module tm1640_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic tm_clk,
   input  logic tm_din,
   output logic start_evt,
   output logic stop_evt,
   output logic bit_evt,
   output logic bit_val
);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   din_prev_q, din_prev_d;
   logic                   cs, ds;

   assign cs = clk_sync_q[SYNC_STAGES-1];
   assign ds = din_sync_q[SYNC_STAGES-1];

   always_comb begin
      clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
      din_sync_d = {din_sync_q[SYNC_STAGES-2:0], tm_din};
      clk_prev_d = cs;
      din_prev_d = ds;
   end

   // Left unreset so the chain keeps tracking the pins through a reset; forcing
   // a value here would fake a start edge when reset hits mid-frame.
   always_ff @(posedge clk) begin
      clk_sync_q <= clk_sync_d;
      din_sync_q <= din_sync_d;
      clk_prev_q <= clk_prev_d;
      din_prev_q <= din_prev_d;
   end

   assign start_evt = clk_prev_q & cs & din_prev_q & ~ds;
   assign stop_evt  = clk_prev_q & cs & ~din_prev_q & ds;
   assign bit_evt   = ~clk_prev_q & cs;
   assign bit_val   = ds;

endmodule

// File: rtl/tm1640_rx.sv
// rtl/tm1640_rx.sv - TM1640 responder: decodes commands into a display RAM mirror and control state.
module tm1640_rx
   import tm1640_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_DIGITS  = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tm_clk,
   input  logic                    tm_din,
   output logic [8*NUM_DIGITS-1:0] data_pack,
   output logic                    disp_on,
   output logic [2:0]              level,
   output logic                    byte_valid,
   output logic [7:0]              byte_data,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic                    busy
);

   logic start_evt, stop_evt, bit_evt, bit_val;

   tm1640_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk       (clk),
      .tm_clk    (tm_clk),
      .tm_din    (tm_din),
      .start_evt (start_evt),
      .stop_evt  (stop_evt),
      .bit_evt   (bit_evt),
      .bit_val   (bit_val)
   );

   state_e                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [6:0]              shift_q, shift_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    fixed_q, fixed_d;
   logic                    dirty_q, dirty_d;
   byte_t                   ram_q [RAM_DEPTH];
   byte_t                   ram_d [RAM_DEPTH];
   logic [8*NUM_DIGITS-1:0] pack_q, pack_d;
   logic                    disp_on_q, disp_on_d;
   logic [2:0]              level_q, level_d;
   logic                    byte_valid_q, byte_valid_d;
   byte_t                   byte_data_q, byte_data_d;
   logic                    frame_done_q, frame_done_d;
   logic                    frame_err_q, frame_err_d;
   logic                    busy_q, busy_d;
   byte_t                   rx_byte;

   // Bits arrive LSB first, so the eighth bit lands on top of the seven held.
   assign rx_byte = {bit_val, shift_q};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      addr_d       = addr_q;
      fixed_d      = fixed_q;
      dirty_d      = dirty_q;
      ram_d        = ram_q;
      pack_d       = pack_q;
      disp_on_d    = disp_on_q;
      level_d      = level_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      busy_d       = busy_q;

      if (start_evt) begin
         if (busy_q && (cnt_q != 3'd0)) frame_err_d = 1'b1;
         if (!busy_q) dirty_d = 1'b0;
         state_d = CMD;
         busy_d  = 1'b1;
         cnt_d   = 3'd0;
      end else if (stop_evt) begin
         frame_done_d = 1'b1;
         if (cnt_q != 3'd0) frame_err_d = 1'b1;
         if (dirty_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) pack_d[8*i +: 8] = ram_q[i];
         end
         state_d = IDLE;
         busy_d  = 1'b0;
         cnt_d   = 3'd0;
         dirty_d = 1'b0;
      end else if (bit_evt && (state_q != IDLE)) begin
         shift_d = rx_byte[7:1];
         cnt_d   = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = rx_byte;
            case (state_q)
               CMD: begin
                  case (rx_byte[7:6])
                     CMD_DATA: begin
                        fixed_d = rx_byte[MODE_BIT];
                        state_d = SKIP;
                     end
                     CMD_DISP: begin
                        disp_on_d = rx_byte[3];
                        level_d   = rx_byte[2:0];
                        state_d   = SKIP;
                     end
                     CMD_ADDR: begin
                        addr_d  = rx_byte[ADDR_W-1:0];
                        state_d = DATA;
                     end
                     default: begin
                        frame_err_d = 1'b1;
                        state_d     = SKIP;
                     end
                  endcase
               end
               DATA: begin
                  ram_d[addr_q] = rx_byte;
                  dirty_d       = 1'b1;
                  if (!fixed_q) addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         shift_q      <= 7'd0;
         addr_q       <= '0;
         fixed_q      <= 1'b0;
         dirty_q      <= 1'b0;
         for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'd0;
         pack_q       <= '0;
         disp_on_q    <= 1'b0;
         level_q      <= 3'd0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'd0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         addr_q       <= addr_d;
         fixed_q      <= fixed_d;
         dirty_q      <= dirty_d;
         ram_q        <= ram_d;
         pack_q       <= pack_d;
         disp_on_q    <= disp_on_d;
         level_q      <= level_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

   assign data_pack  = pack_q;
   assign disp_on    = disp_on_q;
   assign level      = level_q;
   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_tm1640_rx.sv
// tb/tb_tm1640_rx.sv - table-driven frame vectors plus hand sequences for tm1640_rx.
module tb_tm1640_rx;

   localparam int ND = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            tm_clk = 1'b1;
   logic            tm_din = 1'b1;
   logic [8*ND-1:0] data_pack;
   logic            disp_on;
   logic [2:0]      level;
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            frame_done;
   logic            frame_err;
   logic            busy;

   tm1640_rx #(.SYNC_STAGES(2), .NUM_DIGITS(ND)) dut (
      .clk        (clk),
      .rst        (rst),
      .tm_clk     (tm_clk),
      .tm_din     (tm_din),
      .data_pack  (data_pack),
      .disp_on    (disp_on),
      .level      (level),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int bv_cnt = 0, fd_cnt = 0, fe_cnt = 0, fdfe_cnt = 0;
   int lat = -1;

   always @(negedge clk) begin
      if (byte_valid) bv_cnt++;
      if (frame_done) fd_cnt++;
      if (frame_err) fe_cnt++;
      if (frame_done && frame_err) fdfe_cnt++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      tm_din = 1'b0;
      wait_clks(4);
   endtask

   // Bit ends with tm_clk high; lat records clocks from the rising edge to byte_valid.
   task automatic send_bit(input logic b);
      tm_clk = 1'b0;
      wait_clks(2);
      tm_din = b;
      wait_clks(2);
      tm_clk = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (byte_valid && lat < 0) lat = i;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   // With tm_clk high, dropping din first is a harmless start at a byte boundary.
   task automatic bus_stop();
      if (tm_din) begin
         tm_din = 1'b0;
         wait_clks(4);
      end
      tm_din = 1'b1;
      wait_clks(6);
   endtask

   typedef struct {
      string        name;
      int           nb;
      logic [87:0]  bytes;
      int           exp_bv;
      int           exp_err;
      logic [127:0] exp_pack;
      logic         exp_on;
      logic [2:0]   exp_level;
   } vec_t;

   vec_t vecs [8];

   localparam logic [127:0] PACK_DIG  = {56'h0, 72'h7F_07_7D_6D_66_4F_5B_06_3F};
   localparam logic [127:0] PACK_FIX  = {56'h0, 72'h7F_07_7D_55_66_4F_5B_06_3F};
   localparam logic [127:0] PACK_WRAP = {8'h11, 48'h0, 72'h7F_07_7D_55_66_4F_5B_06_22};

   initial begin
      int bv0, fd0, fe0, fdfe0;
      logic [7:0] last;

      vecs[0] = '{"mode_auto",  1, 88'h40, 1, 0, 128'h0, 1'b0, 3'd0};
      vecs[1] = '{"digits",    10, 88'h7F_07_7D_6D_66_4F_5B_06_3F_C0, 10, 0, PACK_DIG, 1'b0, 3'd0};
      vecs[2] = '{"disp_ctl",   1, 88'h8F, 1, 0, PACK_DIG, 1'b1, 3'd7};
      vecs[3] = '{"mode_fixed", 1, 88'h44, 1, 0, PACK_DIG, 1'b1, 3'd7};
      vecs[4] = '{"fixed_wr",   3, 88'h55_AA_C5, 3, 0, PACK_FIX, 1'b1, 3'd7};
      vecs[5] = '{"mode_auto2", 1, 88'h40, 1, 0, PACK_FIX, 1'b1, 3'd7};
      vecs[6] = '{"wrap",       3, 88'h22_11_CF, 3, 0, PACK_WRAP, 1'b1, 3'd7};
      vecs[7] = '{"bad_cmd",    1, 88'h00, 1, 1, PACK_WRAP, 1'b1, 3'd7};

      wait_clks(6);
      rst = 1'b0;
      wait_clks(4);
      check("rst_pack", data_pack, 128'h0);
      check("rst_disp", {disp_on, level}, 4'h0);
      check("rst_bdata", byte_data, 8'h0);
      check("rst_pulses", {byte_valid, frame_done, frame_err, busy}, 4'h0);

      for (int v = 0; v < 8; v++) begin
         bv0 = bv_cnt; fd0 = fd_cnt; fe0 = fe_cnt;
         bus_start();
         check({vecs[v].name, "_busy"}, busy, 1'b1);
         for (int k = 0; k < vecs[v].nb; k++) begin
            lat = -1;
            send_byte(vecs[v].bytes[8*k +: 8]);
            if (v == 0) check("latency", lat, 3);
         end
         last = vecs[v].bytes[8*(vecs[v].nb-1) +: 8];
         bus_stop();
         check({vecs[v].name, "_bv"}, bv_cnt - bv0, vecs[v].exp_bv);
         check({vecs[v].name, "_done"}, fd_cnt - fd0, 1);
         check({vecs[v].name, "_err"}, fe_cnt - fe0, vecs[v].exp_err);
         check({vecs[v].name, "_pack"}, data_pack, vecs[v].exp_pack);
         check({vecs[v].name, "_disp"}, {disp_on, level}, {vecs[v].exp_on, vecs[v].exp_level});
         check({vecs[v].name, "_bdata"}, byte_data, last);
         check({vecs[v].name, "_idle"}, busy, 1'b0);
      end

      // Partial byte at stop: error and done together, RAM untouched.
      bv0 = bv_cnt; fd0 = fd_cnt; fe0 = fe_cnt; fdfe0 = fdfe_cnt;
      bus_start();
      send_byte(8'hC0);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      bus_stop();
      check("partial_bv", bv_cnt - bv0, 1);
      check("partial_err", fe_cnt - fe0, 1);
      check("partial_together", fdfe_cnt - fdfe0, 1);
      check("partial_pack", data_pack, PACK_WRAP);

      // Repeated start after 0xC2 plus 3 bits (raising din adds a 4th bit).
      bv0 = bv_cnt; fd0 = fd_cnt; fe0 = fe_cnt;
      bus_start();
      send_byte(8'hC2);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      tm_clk = 1'b0; wait_clks(2);
      tm_din = 1'b1; wait_clks(2);
      tm_clk = 1'b1; wait_clks(4);
      tm_din = 1'b0; wait_clks(4);
      check("rs_busy", busy, 1'b1);
      send_byte(8'h8B);
      bus_stop();
      check("rs_err", fe_cnt - fe0, 1);
      check("rs_done", fd_cnt - fd0, 1);
      check("rs_bv", bv_cnt - bv0, 2);
      check("rs_disp", {disp_on, level}, 4'hB);
      check("rs_pack", data_pack, PACK_WRAP);

      // Reset mid-frame, then bits without a start are ignored.
      bus_start();
      send_byte(8'hC0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rst = 1'b1;
      wait_clks(1);
      rst = 1'b0;
      check("mrst_pack", data_pack, 128'h0);
      check("mrst_disp", {disp_on, level}, 4'h0);
      check("mrst_bdata", byte_data, 8'h0);
      check("mrst_busy", busy, 1'b0);
      bv0 = bv_cnt;
      send_byte(8'h55);
      check("nostart_bv", bv_cnt - bv0, 0);
      check("nostart_busy", busy, 1'b0);
      bus_stop();

      // Recovery after reset: auto mode is the default.
      bv0 = bv_cnt; fe0 = fe_cnt;
      bus_start();
      send_byte(8'hC3);
      send_byte(8'hAB);
      send_byte(8'h12);
      bus_stop();
      check("recover_bv", bv_cnt - bv0, 3);
      check("recover_err", fe_cnt - fe0, 0);
      check("recover_pack", data_pack, 128'h12_AB_00_00_00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/tm1640_rx.md
Name: tm1640_rx

Overview:
- Responder side of the TM1640 two-wire display bus: decodes the CLK/DIN stream driven by our TM1640 controller chain.
- Holds a 16-byte display RAM mirror and exposes digits 1-9 as a 72-bit pack plus on/brightness state.
- Used as on-FPGA loopback checker, display emulator and bench scoreboard source; sits beside the 7seg9 controller, fed from the same tm_clk/tm_din nets.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on tm_clk and tm_din (minimum 2).
- NUM_DIGITS, 9, number of RAM bytes exported on data_pack (1..16).

Ports:
- clk  in  1  system clock; must be at least 4x the tm_clk bit rate.
- rst  in  1  synchronous, active-high reset.
- tm_clk  in  1  bus clock from the driver (asynchronous).
- tm_din  in  1  bus data from the driver (asynchronous).
- data_pack  out  8*NUM_DIGITS  RAM bytes 0..NUM_DIGITS-1; digit 1 in [7:0].
- disp_on  out  1  display-control ON bit.
- level  out  3  display-control brightness.
- byte_valid  out  1  one-cycle pulse per complete received byte.
- byte_data  out  8  last received byte; valid with byte_valid, held otherwise.
- frame_done  out  1  one-cycle pulse on every stop condition.
- frame_err  out  1  one-cycle pulse on any protocol error.
- busy  out  1  high from start condition until stop condition.

Behaviour:
- Reset values:
  - data_pack=0, RAM=0, disp_on=0, level=0, byte_data=0.
  - All pulses=0, busy=0, addr=0, mode=auto-increment, state=IDLE.
- Line sampling:
  - Both lines pass through SYNC_STAGES flops; cs/ds = synchronized current samples, cp/dp = previous samples.
  - Start: cp=1, cs=1, dp=1, ds=0.
  - Stop: cp=1, cs=1, dp=0, ds=1.
  - Bit: cp=0, cs=1 (rising edge); capture ds. Bits are LSB first.
  - Start/stop evaluation takes priority over bit capture.
- State machine IDLE / CMD / DATA / SKIP:
  - IDLE: ignores bits. Start -> CMD, busy=1, bit count=0.
  - CMD, on 8th bit, decoded by byte[7:6]:
    - 01: mode = byte[2] (0 auto, 1 fixed) -> SKIP.
    - 10: disp_on=byte[3], level=byte[2:0] -> SKIP.
    - 11: addr=byte[3:0] -> DATA.
    - 00: frame_err pulse -> SKIP.
  - DATA: each byte writes RAM[addr]. In auto mode addr increments mod 16 (15 wraps to 0); in fixed mode addr is unchanged.
  - SKIP: further complete bytes pulse byte_valid only, with no register or RAM effect.
- Stop condition:
  - frame_done pulse, busy=0 -> IDLE.
  - If the bit count is not 0 at stop, the partial byte is discarded and frame_err pulses in the same cycle.
  - data_pack is reloaded from RAM in the stop cycle if the frame wrote RAM, so updates appear atomically. disp_on/level update immediately.
- Start while busy (repeated start):
  - Aborts the current byte -> CMD.
  - frame_err pulses if the bit count was not 0.
  - data_pack is not refreshed.
- Latency: byte_valid asserts 1 clk after the cycle in which the 8th rising edge is detected, i.e. SYNC_STAGES+1 clks after the pin edge.
- Mode persists across frames until the next data-setting command.
- Reset mid-frame:
  - Everything returns to reset values.
  - Bits on the bus before the next start condition are ignored.

Decomposition:
- Package tm1640_pkg:
  - Command class constants CMD_DATA=2'b01, CMD_DISP=2'b10, CMD_ADDR=2'b11.
  - MODE_BIT=2, RAM_DEPTH=16, ADDR_W=4.
  - State enum {IDLE, CMD, DATA, SKIP}.
- Sub-module tm1640_line_sync: synchronizers plus start/stop/bit-edge detection. Outputs start_evt, stop_evt, bit_evt and bit_val.

Test Plan:
- Data frame: frames 0x40 | 0xC0,0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F | 0x8F.
  - data_pack = 0x7F_07_7D_6D_66_4F_5B_06_3F; disp_on=1, level=7.
  - 12 byte_valid pulses, 3 frame_done pulses, no frame_err.
- Fixed address: 0x44 | 0xC5,0xAA,0x55.
  - RAM[5]=0x55 (last write wins); data_pack[47:40]=0x55; RAM[6] unchanged.
- Auto-increment wrap: 0x40 | 0xCF,0x11,0x22.
  - RAM[15]=0x11, RAM[0]=0x22; data_pack[7:0]=0x22.
- Errors:
  - 0x00 command -> frame_err pulse and no state change.
  - 0xC0 followed by 5 bits then stop -> frame_err and frame_done in the same cycle; RAM[0] unchanged.
- Repeated start: 0xC2 plus 3 bits, then a new start and 0x8B stop.
  - frame_err pulses once; disp_on=1, level=3; data_pack unchanged.
- Reset: rst for 1 clk after 0xC0 plus 4 bits.
  - All outputs return to reset values; the next 8 bits without a start give no byte_valid.
